tile_writeback_sequencer: RTL and testbench
===========================================

// Module: tile_writeback_sequencer
// PURPOSE
//  Consumer end of the frame_tiler tile-descriptor interface. Accepts finished-tile descriptors
//  (tile row/col index and extent) from the compute path over valid/ready. Expands each tile into
//  a raster-order stream of output-frame pixel addresses for the write-back buffer.
//  Counts written pixels and pulses frame_done once the whole H x W frame has been covered.
// PARAMETERS
//  WIDTH   16  width of dimension, index and extent fields
//  ADDR_W  32  width of output pixel address (must hold frame_H*frame_W-1)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  start          in   1       arm new frame; latches frame_H/frame_W/tile_rows/tile_cols_max
//  frame_H        in   WIDTH   frame height, pixels
//  frame_W        in   WIDTH   frame width, pixels
//  tile_rows      in   WIDTH   nominal tile height; row_base = in_row_idx*tile_rows
//  tile_cols_max  in   WIDTH   nominal tile width; col_base = in_col_idx*tile_cols_max
//  in_valid       in   1       descriptor valid
//  in_ready       out  1       descriptor accepted when in_valid&&in_ready
//  in_row_idx     in   WIDTH   tile row index
//  in_col_idx     in   WIDTH   tile column index
//  in_rows        in   WIDTH   rows in this tile (edge tiles may be short)
//  in_cols        in   WIDTH   cols in this tile
//  out_valid      out  1       out_addr valid
//  out_ready      in   1       downstream accepts address
//  out_addr       out  ADDR_W  (row_base+r)*frame_W + col_base + c
//  out_tile_last  out  1       qualifies last pixel of current tile
//  out_frame_last out  1       qualifies last pixel of frame
//  busy           out  1       high in any state except IDLE
//  frame_done     out  1       one-cycle pulse after frame's last pixel handshake
//  err            out  1       sticky; tile rejected (bounds/zero extent); cleared by start or rst
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, out_tile_last, out_frame_last, busy, frame_done, err = 0;
//   out_addr = 0; all counters 0. Reset mid-tile abandons the tile, no pulse.
//  FSM IDLE -> ACCEPT -> EMIT -> (ACCEPT | DONE) -> IDLE.
//  IDLE: start=1 latches config; pix_cnt=0; err=0; total=frame_H*frame_W -> ACCEPT.
//   start in any other state is ignored. start with frame_H==0 or frame_W==0 -> DONE directly.
//  ACCEPT: in_ready=1 (registered, combinationally independent of in_valid). On handshake, latch
//   descriptor; compute row_base, col_base. Reject if in_rows==0, in_cols==0,
//   row_base+in_rows>frame_H or col_base+in_cols>frame_W: set err, stay ACCEPT, emit nothing.
//   Else r=c=0, line_addr=row_base*frame_W+col_base -> EMIT; in_ready drops same edge.
//  EMIT: out_valid=1 from cycle after accepting handshake (1-cycle latency); out_addr=line_addr+c.
//   Outputs held stable while out_valid&&!out_ready. On handshake: pix_cnt++; c++;
//   if c==in_cols-1: c=0, r++, line_addr+=frame_W. No multiply in EMIT loop.
//   Last pixel (r==in_rows-1,c==in_cols-1): out_tile_last=1; if pix_cnt+1==total also
//   out_frame_last=1. After handshake -> DONE if frame complete else ACCEPT (no bubble
//   requirement beyond one cycle of in_ready).
//  DONE: frame_done=1 for exactly one cycle, busy=1 -> IDLE.
//  Arithmetic: products/sums computed at ADDR_W, zero-extended; bounds compare at WIDTH+1 bits
//   so row_base+in_rows overflow is detected, not wrapped.
//  Overlapping tiles not detected; coverage is by pixel count only.
//  Throughput: 1 address/cycle in EMIT with out_ready=1.
// STRUCTURE
//  Shared header vcnpu_defs.vh: FSM state encodings (ST_IDLE/ACCEPT/EMIT/DONE), default
//   WIDTH/ADDR_W, descriptor field widths shared with frame_tiler.
//  One sub-module: tile_addr_gen (r/c counters, line_addr accumulator, tile_last detect);
//   top holds FSM, config latches, bounds check, pix_cnt and frame_done.
// TESTING
//  1 H=4,W=6,tile_rows=2,tile_cols_max=4; tiles (0,0,2,4),(0,1,2,2),(1,0,2,4),(1,1,2,2), out_ready=1
//    -> 24 addrs: 0,1,2,3,6,7,8,9 | 4,5,10,11 | 12..15,18..21 | 16,17,22,23; tile_last 4x;
//    frame_last on 23; frame_done one cycle after; busy low next.
//  2 Same frame, out_ready toggling 1/0 random -> identical address sequence, addr stable while
//    stalled, no drop/duplicate.
//  3 Tile (1,1,3,2) on H=4 (row_base 2+3>4) -> err=1, zero addresses emitted, in_ready stays 1;
//    next valid tile processed normally; err stays 1 until next start.
//  4 Reset asserted during EMIT at pixel 5 -> next cycle all outputs 0, IDLE; fresh start runs
//    scenario 1 cleanly.
//  5 start pulsed during EMIT with different frame_W -> ignored; addresses use original W.
//  6 H=1,W=1, tile (0,0,1,1) -> single addr 0 with tile_last=frame_last=1, frame_done pulse.

Source files
------------

// File: rtl/tile_writeback_sequencer_pkg.sv
// Shared definitions for the tile write-back sequencer: FSM encoding and default field widths.
// The descriptor field widths are kept in step with the frame_tiler producer.
package tile_writeback_sequencer_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_EMIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/tile_writeback_sequencer_addr_gen.sv
// Raster walker for one tile: row/col counters plus a running line-start address.
// Row advance adds frame_w to line_addr, so no multiplier sits in the per-pixel loop.
module tile_writeback_sequencer_addr_gen
   import tile_writeback_sequencer_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] line_base,
   input  logic [WIDTH-1:0]  rows,
   input  logic [WIDTH-1:0]  cols,
   input  logic [WIDTH-1:0]  frame_w,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              tile_last
);

   logic [WIDTH-1:0]  r_q, r_d;
   logic [WIDTH-1:0]  c_q, c_d;
   logic [WIDTH-1:0]  rows_q, rows_d;
   logic [WIDTH-1:0]  cols_q, cols_d;
   logic [ADDR_W-1:0] line_q, line_d;
   logic              row_end;

   assign row_end = (c_q == cols_q - 1'b1);

   always_comb begin
      r_d    = r_q;
      c_d    = c_q;
      rows_d = rows_q;
      cols_d = cols_q;
      line_d = line_q;
      if (load) begin
         r_d    = '0;
         c_d    = '0;
         rows_d = rows;
         cols_d = cols;
         line_d = line_base;
      end else if (advance) begin
         if (row_end) begin
            c_d    = '0;
            r_d    = r_q + 1'b1;
            line_d = line_q + ADDR_W'(frame_w);
         end else begin
            c_d = c_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         c_q    <= '0;
         rows_q <= '0;
         cols_q <= '0;
         line_q <= '0;
      end else begin
         r_q    <= r_d;
         c_q    <= c_d;
         rows_q <= rows_d;
         cols_q <= cols_d;
         line_q <= line_d;
      end
   end

   assign addr      = line_q + ADDR_W'(c_q);
   assign tile_last = row_end && (r_q == rows_q - 1'b1);

endmodule

// File: rtl/tile_writeback_sequencer.sv
// Consumes finished-tile descriptors and streams raster-order frame addresses to write-back,
// counting pixels until the whole frame is covered.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start; config latched on start
//   ST_ACCEPT | in_ready high; bounds-check incoming descriptor
//   ST_EMIT   | out_valid high; one address per out handshake
//   ST_DONE   | one-cycle frame_done pulse, then back to idle
module tile_writeback_sequencer
   import tile_writeback_sequencer_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  frame_H,
   input  logic [WIDTH-1:0]  frame_W,
   input  logic [WIDTH-1:0]  tile_rows,
   input  logic [WIDTH-1:0]  tile_cols_max,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_row_idx,
   input  logic [WIDTH-1:0]  in_col_idx,
   input  logic [WIDTH-1:0]  in_rows,
   input  logic [WIDTH-1:0]  in_cols,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_tile_last,
   output logic              out_frame_last,
   output logic              busy,
   output logic              frame_done,
   output logic              err
);

   localparam int AW1 = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  h_q, h_d;
   logic [WIDTH-1:0]  w_q, w_d;
   logic [WIDTH-1:0]  tr_q, tr_d;
   logic [WIDTH-1:0]  tc_q, tc_d;
   logic [ADDR_W-1:0] total_q, total_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] row_base, col_base, line_base, pix_next;
   logic [AW1-1:0]    row_end, col_end;
   logic              reject, hs_in, hs_out, load, tile_last, frame_hit;

   assign row_base  = ADDR_W'(in_row_idx) * ADDR_W'(tr_q);
   assign col_base  = ADDR_W'(in_col_idx) * ADDR_W'(tc_q);
   assign line_base = row_base * ADDR_W'(w_q) + col_base;

   // One extra bit so a base+extent that wraps ADDR_W still reads as out of bounds.
   assign row_end = {1'b0, row_base} + AW1'(in_rows);
   assign col_end = {1'b0, col_base} + AW1'(in_cols);
   assign reject  = (in_rows == '0) || (in_cols == '0) ||
                    (row_end > AW1'(h_q)) || (col_end > AW1'(w_q));

   assign in_ready  = (state_q == ST_ACCEPT);
   assign out_valid = (state_q == ST_EMIT);
   assign hs_in     = in_valid && in_ready;
   assign hs_out    = out_valid && out_ready;
   assign load      = hs_in && !reject;
   assign pix_next  = pix_cnt_q + 1'b1;
   assign frame_hit = (pix_next == total_q);

   tile_writeback_sequencer_addr_gen #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .line_base (line_base),
      .rows      (in_rows),
      .cols      (in_cols),
      .frame_w   (w_q),
      .advance   (hs_out),
      .addr      (out_addr),
      .tile_last (tile_last)
   );

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      w_d       = w_q;
      tr_d      = tr_q;
      tc_d      = tc_q;
      total_d   = total_q;
      pix_cnt_d = pix_cnt_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               h_d       = frame_H;
               w_d       = frame_W;
               tr_d      = tile_rows;
               tc_d      = tile_cols_max;
               total_d   = ADDR_W'(frame_H) * ADDR_W'(frame_W);
               pix_cnt_d = '0;
               err_d     = 1'b0;
               state_d   = ((frame_H == '0) || (frame_W == '0)) ? ST_DONE : ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (hs_in) begin
               if (reject) err_d   = 1'b1;
               else        state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (hs_out) begin
               pix_cnt_d = pix_next;
               if (tile_last) state_d = frame_hit ? ST_DONE : ST_ACCEPT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         h_q       <= '0;
         w_q       <= '0;
         tr_q      <= '0;
         tc_q      <= '0;
         total_q   <= '0;
         pix_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         w_q       <= w_d;
         tr_q      <= tr_d;
         tc_q      <= tc_d;
         total_q   <= total_d;
         pix_cnt_q <= pix_cnt_d;
         err_q     <= err_d;
      end
   end

   assign out_tile_last  = out_valid && tile_last;
   assign out_frame_last = out_tile_last && frame_hit;
   assign busy           = (state_q != ST_IDLE);
   assign frame_done     = (state_q == ST_DONE);
   assign err            = err_q;

endmodule

// File: tb/tb_tile_writeback_sequencer.sv
// Directed bench for tile_writeback_sequencer: 4x6 frame of 2x4 tiles, stalls, rejects,
// mid-tile reset, ignored restart, degenerate frames.
module tb_tile_writeback_sequencer;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] frame_H, frame_W, tile_rows, tile_cols_max;
   logic        in_valid, in_ready;
   logic [15:0] in_row_idx, in_col_idx, in_rows, in_cols;
   logic        out_valid, out_ready;
   logic [31:0] out_addr;
   logic        out_tile_last, out_frame_last, busy, frame_done, err;

   int checks = 0;
   int passes = 0;

   int unsigned exq[$];
   bit          exq_tl[$];
   bit          exq_fl[$];

   tile_writeback_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .frame_H        (frame_H),
      .frame_W        (frame_W),
      .tile_rows      (tile_rows),
      .tile_cols_max  (tile_cols_max),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_row_idx     (in_row_idx),
      .in_col_idx     (in_col_idx),
      .in_rows        (in_rows),
      .in_cols        (in_cols),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_addr       (out_addr),
      .out_tile_last  (out_tile_last),
      .out_frame_last (out_frame_last),
      .busy           (busy),
      .frame_done     (frame_done),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic push(input int unsigned a, input bit tl, input bit fl);
      exq.push_back(a);
      exq_tl.push_back(tl);
      exq_fl.push_back(fl);
   endtask

   task automatic clear_q();
      exq.delete();
      exq_tl.delete();
      exq_fl.delete();
   endtask

   // Hand-derived raster order for H=4,W=6 with 2x4 nominal tiles.
   task automatic push_frame1();
      int unsigned seq[24] = '{0, 1, 2, 3, 6, 7, 8, 9, 4, 5, 10, 11,
                               12, 13, 14, 15, 18, 19, 20, 21, 16, 17, 22, 23};
      for (int i = 0; i < 24; i++)
         push(seq[i], (i == 7) || (i == 11) || (i == 19) || (i == 23), i == 23);
   endtask

   task automatic do_start(input int h, input int w, input int tr, input int tc);
      start = 1'b1;
      frame_H = 16'(h);
      frame_W = 16'(w);
      tile_rows = 16'(tr);
      tile_cols_max = 16'(tc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_tile(input int ri, input int ci, input int rows, input int cols);
      int cyc = 0;
      in_valid = 1'b1;
      in_row_idx = 16'(ri);
      in_col_idx = 16'(ci);
      in_rows = 16'(rows);
      in_cols = 16'(cols);
      @(negedge clk);
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(input int n, input bit rnd);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            chk("out_addr", 64'(out_addr), 64'(exq[0]));
            if (out_ready) begin
               chk("tile_last", 64'(out_tile_last), 64'(exq_tl[0]));
               chk("frame_last", 64'(out_frame_last), 64'(exq_fl[0]));
               void'(exq.pop_front());
               void'(exq_tl.pop_front());
               void'(exq_fl.pop_front());
               got++;
            end
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (got < n) chk("collect_timeout", 64'(got), 64'(n));
   endtask

   task automatic frame1_tile(input int k, input bit rnd);
      case (k)
         0: begin send_tile(0, 0, 2, 4); collect(8, rnd); end
         1: begin send_tile(0, 1, 2, 2); collect(4, rnd); end
         2: begin send_tile(1, 0, 2, 4); collect(8, rnd); end
         default: begin send_tile(1, 1, 2, 2); collect(4, rnd); end
      endcase
   endtask

   task automatic check_done();
      chk("done_pulse", 64'(frame_done), 64'd1);
      chk("done_busy", 64'(busy), 64'd1);
      chk("done_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("done_drop", 64'(frame_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      frame_H = '0;
      frame_W = '0;
      tile_rows = '0;
      tile_cols_max = '0;
      in_valid = 1'b0;
      in_row_idx = '0;
      in_col_idx = '0;
      in_rows = '0;
      in_cols = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full frame, out_ready held high.
      do_start(4, 6, 2, 4);
      chk("s1_in_ready", 64'(in_ready), 64'd1);
      chk("s1_busy", 64'(busy), 64'd1);
      push_frame1();
      send_tile(0, 0, 2, 4);
      chk("s1_latency", 64'(out_valid), 64'd1);
      chk("s1_ready_drop", 64'(in_ready), 64'd0);
      collect(8, 1'b0);
      for (int k = 1; k < 4; k++) frame1_tile(k, 1'b0);
      check_done();

      // Same frame with random back-pressure.
      do_start(4, 6, 2, 4);
      push_frame1();
      for (int k = 0; k < 4; k++) frame1_tile(k, 1'b1);
      check_done();

      // Out-of-bounds tile rejected, frame then completes with err sticky.
      do_start(4, 6, 2, 4);
      chk("s3_err_clear", 64'(err), 64'd0);
      send_tile(1, 1, 3, 2);
      for (int i = 0; i < 3; i++) begin
         chk("s3_err", 64'(err), 64'd1);
         chk("s3_in_ready", 64'(in_ready), 64'd1);
         chk("s3_no_valid", 64'(out_valid), 64'd0);
         @(posedge clk); #1;
      end
      push_frame1();
      for (int k = 0; k < 4; k++) frame1_tile(k, 1'b0);
      check_done();
      chk("s3_err_sticky", 64'(err), 64'd1);

      // 1x1 frame; the start also clears err.
      do_start(1, 1, 1, 1);
      chk("s6_err_cleared", 64'(err), 64'd0);
      push(0, 1'b1, 1'b1);
      send_tile(0, 0, 1, 1);
      collect(1, 1'b0);
      check_done();

      // Reset during EMIT with pixel 5 presented.
      do_start(4, 6, 2, 4);
      push_frame1();
      send_tile(0, 0, 2, 4);
      collect(5, 1'b0);
      chk("s4_pre_valid", 64'(out_valid), 64'd1);
      chk("s4_pre_addr", 64'(out_addr), 64'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("s4_out_valid", 64'(out_valid), 64'd0);
      chk("s4_out_addr", 64'(out_addr), 64'd0);
      chk("s4_tile_last", 64'(out_tile_last), 64'd0);
      chk("s4_frame_last", 64'(out_frame_last), 64'd0);
      chk("s4_in_ready", 64'(in_ready), 64'd0);
      chk("s4_busy", 64'(busy), 64'd0);
      chk("s4_frame_done", 64'(frame_done), 64'd0);
      rst = 1'b0;
      clear_q();
      @(posedge clk); #1;
      chk("s4_no_pulse", 64'(frame_done), 64'd0);
      do_start(4, 6, 2, 4);
      push_frame1();
      for (int k = 0; k < 4; k++) frame1_tile(k, 1'b0);
      check_done();

      // start during EMIT with a different geometry is ignored.
      do_start(4, 6, 2, 4);
      push_frame1();
      send_tile(0, 0, 2, 4);
      collect(3, 1'b0);
      start = 1'b1;
      frame_H = 16'd2;
      frame_W = 16'd8;
      @(posedge clk); #1;
      start = 1'b0;
      chk("s5_busy", 64'(busy), 64'd1);
      chk("s5_addr_hold", 64'(out_addr), 64'd3);
      collect(5, 1'b0);
      for (int k = 1; k < 4; k++) frame1_tile(k, 1'b0);
      check_done();

      // Zero-height frame goes straight to the done pulse.
      do_start(0, 6, 2, 4);
      check_done();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
